// File: rtl/qam_modulator_tx.sv
// qam_modulator_tx: 4-QAM transmit stage feeding the QAM demodulator.
// Takes 2-bit symbols over a valid/ready handshake and holds each one for
// SYM_PERIODS carrier periods (16 samples per period). It emits the modulated
// 8-bit signed sample stream and the sin/cos carrier references, all three
// built from the same carrier phase on every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   sym_in     symbol: bit1 = sin (Q) sign, bit0 = cos (I) sign, 1 = +
//   sym_valid  sym_in valid
//   sym_ready  hold register empty, symbol can be accepted
//   tx_signal  signed modulated sample
//   sin_out    signed sin carrier reference
//   cos_out    signed cos carrier reference
//   tx_active  current sample belongs to a transmitted symbol
//   sym_strobe pulse on the first sample of each transmitted symbol
//   underrun   sticky starvation flag (only with QAM_TX_UNDERRUN_EN defined)
//
// Build option: define QAM_TX_UNDERRUN_EN to add the underrun port.

module qam_modulator_tx #(
    parameter int unsigned SYM_PERIODS = 4,
    parameter int unsigned OUT_SHIFT   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [7:0] tx_signal,
    output logic [7:0] sin_out,
    output logic [7:0] cos_out,
    output logic       tx_active,
    output logic       sym_strobe
`ifdef QAM_TX_UNDERRUN_EN
    ,
    output logic       underrun
`endif
);

    localparam int unsigned SYM_LEN = 16 * SYM_PERIODS;
    localparam int unsigned CNT_W   = $clog2(SYM_LEN);

    typedef enum logic {ST_IDLE, ST_TX} state_e;

    state_e                  state_q;
    logic                    started_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    hold_full_q;
    logic [1:0]              hold_q;
    logic [1:0]              act_q;

    logic                    transfer_c;
    logic                    boundary_c;
    logic                    avail_c;
    logic [1:0]              new_sym_c;
    logic [1:0]              sym_sel_c;
    logic [CNT_W-1:0]        cnt_d;
    logic [3:0]              k_c;
    logic signed [7:0]       sin_c;
    logic signed [7:0]       cos_c;
    logic signed [8:0]       i_c;
    logic signed [8:0]       q_c;
    logic signed [8:0]       sum_c;
    logic [7:0]              tx_c;
    logic                    ready_d;

    // Quarter-wave symmetric 16-point sine table
    function automatic logic signed [7:0] sine_lut(input logic [3:0] k);
        logic signed [7:0] v;
        case (k)
            4'd0:    v = 8'sd0;
            4'd1:    v = 8'sd49;
            4'd2:    v = 8'sd90;
            4'd3:    v = 8'sd117;
            4'd4:    v = 8'sd127;
            4'd5:    v = 8'sd117;
            4'd6:    v = 8'sd90;
            4'd7:    v = 8'sd49;
            4'd8:    v = 8'sd0;
            4'd9:    v = -8'sd49;
            4'd10:   v = -8'sd90;
            4'd11:   v = -8'sd117;
            4'd12:   v = -8'sd127;
            4'd13:   v = -8'sd117;
            4'd14:   v = -8'sd90;
            default: v = -8'sd49;
        endcase
        return v;
    endfunction

    // Next-cycle position, carrier phase and modulated sample
    always_comb begin
        transfer_c = sym_valid && sym_ready;
        boundary_c = started_q && (cnt_q == CNT_W'(SYM_LEN - 1));
        avail_c    = hold_full_q || transfer_c;
        new_sym_c  = hold_full_q ? hold_q : sym_in;
        sym_sel_c  = boundary_c ? new_sym_c : act_q;

        if (!started_q || boundary_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // SYM_LEN is a multiple of 16, so the slot position's low bits are the phase
        k_c   = cnt_d[3:0];
        sin_c = sine_lut(k_c);
        cos_c = sine_lut(k_c + 4'd4);

        i_c   = sym_sel_c[0] ? {cos_c[7], cos_c} : -{cos_c[7], cos_c};
        q_c   = sym_sel_c[1] ? {sin_c[7], sin_c} : -{sin_c[7], sin_c};
        sum_c = i_c + q_c;
        tx_c  = 8'(sum_c >>> OUT_SHIFT);

        // The boundary always empties the hold register
        ready_d = boundary_c ? 1'b1 : !(hold_full_q || transfer_c);
    end

    // Handshake FSM, hold register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            started_q   <= 1'b0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            hold_q      <= 2'b00;
            act_q       <= 2'b00;
            sym_ready   <= 1'b0;
            tx_signal   <= 8'h00;
            sin_out     <= 8'h00;
            cos_out     <= 8'h00;
            tx_active   <= 1'b0;
            sym_strobe  <= 1'b0;
`ifdef QAM_TX_UNDERRUN_EN
            underrun    <= 1'b0;
`endif
        end else begin
            started_q  <= 1'b1;
            cnt_q      <= cnt_d;
            sin_out    <= sin_c;
            cos_out    <= cos_c;
            sym_ready  <= ready_d;
            tx_signal  <= 8'h00;
            tx_active  <= 1'b0;
            sym_strobe <= 1'b0;

            if (boundary_c) begin
                hold_full_q <= 1'b0;
                if (avail_c) begin
                    // Held symbol has priority; otherwise the incoming one bypasses
                    state_q    <= ST_TX;
                    act_q      <= new_sym_c;
                    tx_signal  <= tx_c;
                    tx_active  <= 1'b1;
                    sym_strobe <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
`ifdef QAM_TX_UNDERRUN_EN
                    if (state_q == ST_TX) begin
                        underrun <= 1'b1;
                    end
`endif
                end
            end else begin
                if (state_q == ST_TX) begin
                    tx_signal <= tx_c;
                    tx_active <= 1'b1;
                end
                if (transfer_c) begin
                    hold_full_q <= 1'b1;
                    hold_q      <= sym_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_qam_modulator_tx.sv
// Randomized and directed bench for qam_modulator_tx against a slot-level model.
module tb_qam_modulator_tx;

    localparam int SYM_PERIODS = 4;
    localparam int OUT_SHIFT   = 1;
    localparam int SYM_LEN     = 16 * SYM_PERIODS;

    logic       clk;
    logic       rst;
    logic [1:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [7:0] tx_signal;
    logic [7:0] sin_out;
    logic [7:0] cos_out;
    logic       tx_active;
    logic       sym_strobe;
`ifdef QAM_TX_UNDERRUN_EN
    logic       underrun;
`endif

    qam_modulator_tx #(
        .SYM_PERIODS(SYM_PERIODS),
        .OUT_SHIFT  (OUT_SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .tx_signal (tx_signal),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .tx_active (tx_active),
        .sym_strobe(sym_strobe)
`ifdef QAM_TX_UNDERRUN_EN
        ,
        .underrun  (underrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int lut [16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                     0, -49, -90, -117, -127, -117, -90, -49};

    // Model state: cycle index since reset, symbol of current slot (-1 idle), hold register
    int m_n;
    int m_cur;
    bit m_hold_full;
    int m_hold;
    bit m_under;

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got %0d expected %0d", tag, m_n, got, exp);
        end
    endtask

    // Floor division of the I+Q sum by 2**OUT_SHIFT, wrapped to 8-bit signed
    function automatic int exp_tx(input int sym, input int k);
        int i, q, s, d, r;
        i = ((sym & 1) != 0) ? lut[(k + 4) % 16] : -lut[(k + 4) % 16];
        q = ((sym & 2) != 0) ? lut[k] : -lut[k];
        s = i + q;
        d = 1 << OUT_SHIFT;
        r = (s >= 0) ? s / d : -((-s + d - 1) / d);
        return ((r + 128) % 256) - 128;
    endfunction

    task automatic check_cycle();
        int k;
        bit act;
        k   = m_n % 16;
        act = (m_cur >= 0);
        check_val("sin_out",    int'($signed(sin_out)),   lut[k]);
        check_val("cos_out",    int'($signed(cos_out)),   lut[(k + 4) % 16]);
        check_val("tx_active",  int'(tx_active),          int'(act));
        check_val("sym_strobe", int'(sym_strobe),         int'(act && (m_n % SYM_LEN == 0)));
        check_val("tx_signal",  int'($signed(tx_signal)), act ? exp_tx(m_cur, k) : 0);
        check_val("sym_ready",  int'(sym_ready),          int'(!m_hold_full));
`ifdef QAM_TX_UNDERRUN_EN
        check_val("underrun",   int'(underrun),           int'(m_under));
`endif
    endtask

    task automatic model_edge(input logic v, input logic [1:0] s);
        bit xfer;
        int prev;
        xfer = v && !m_hold_full;
        if (m_n % SYM_LEN == SYM_LEN - 1) begin
            prev = m_cur;
            if (m_hold_full)  m_cur = m_hold;
            else if (xfer)    m_cur = int'(s);
            else              m_cur = -1;
            m_hold_full = 1'b0;
            if (prev >= 0 && m_cur < 0) m_under = 1'b1;
        end else if (xfer) begin
            m_hold      = int'(s);
            m_hold_full = 1'b1;
        end
        m_n++;
    endtask

    // Called at a falling edge: check the current cycle, drive, advance one cycle
    task automatic step(input logic v, input logic [1:0] s, output bit acc);
        check_cycle();
        sym_valid = v;
        sym_in    = s;
        acc       = v && !m_hold_full;
        @(posedge clk);
        model_edge(v, s);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cyc);
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_in    = 2'b00;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx_signal",  int'(tx_signal),  0);
        check_val("rst_sin_out",    int'(sin_out),    0);
        check_val("rst_cos_out",    int'(cos_out),    0);
        check_val("rst_tx_active",  int'(tx_active),  0);
        check_val("rst_sym_strobe", int'(sym_strobe), 0);
        check_val("rst_sym_ready",  int'(sym_ready),  0);
`ifdef QAM_TX_UNDERRUN_EN
        check_val("rst_underrun",   int'(underrun),   0);
`endif
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        m_n         = 0;
        m_cur       = -1;
        m_hold_full = 1'b0;
        m_hold      = 0;
        m_under     = 1'b0;
    endtask

    initial begin
        bit acc;
        logic [1:0] burst [4];
        int idx;

        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_in    = 2'b00;

        // Single symbol 11 accepted at cycle 5, with spec spot values
        apply_reset(3);
        while (m_n < 140) begin
            if (m_n == 0)   check_val("spot_cos0", int'($signed(cos_out)), 127);
            if (m_n == 4)   check_val("spot_sin4", int'($signed(sin_out)), 127);
            if (m_n == 64)  check_val("spot_tx64", int'($signed(tx_signal)), 63);
            if (m_n == 66)  check_val("spot_tx66", int'($signed(tx_signal)), 90);
            if (m_n == 128) check_val("spot_act128", int'(tx_active), 0);
            step(m_n == 5, 2'b11, acc);
        end

        // Symbol 00 then 01 back to back
        apply_reset(2);
        while (m_n < 200) begin
            if (m_n == 64)  check_val("spot_tx64_00", int'($signed(tx_signal)), -64);
            if (m_n == 130) check_val("spot_tx130_01", int'($signed(tx_signal)), 0);
            if (m_n == 132) check_val("spot_tx132_01", int'($signed(tx_signal)), -64);
            step(m_n == 5 || m_n == 70, (m_n == 5) ? 2'b00 : 2'b01, acc);
        end

        // sym_valid held high with a burst of 4 symbols from cycle 5
        apply_reset(3);
        burst = '{2'b10, 2'b01, 2'b11, 2'b00};
        idx   = 0;
        while (m_n < 340) begin
            if (m_n == 64 || m_n == 128 || m_n == 192 || m_n == 256)
                check_val("spot_burst_strobe", int'(sym_strobe), 1);
            step(m_n >= 5 && idx < 4, burst[idx % 4], acc);
            if (acc) idx++;
        end
        check_val("burst_accepted", idx, 4);

        // Bypass: hold empty, valid pulsed only at the last cycle of a TX slot
        apply_reset(3);
        while (m_n < 200) begin
            if (m_n == 128) check_val("spot_bypass_strobe", int'(sym_strobe), 1);
            step(m_n == 5 || m_n == 127, (m_n == 5) ? 2'b11 : 2'b10, acc);
        end

        // Reset at cycle 90 with a symbol held: held symbol must never be sent
        apply_reset(3);
        while (m_n < 90) step(m_n == 5 || m_n == 70, (m_n == 5) ? 2'b10 : 2'b01, acc);
        apply_reset(1);
        while (m_n < 140) step(1'b0, 2'b00, acc);

        // Random traffic
        apply_reset(3);
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 7) == 0, 2'($urandom), acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
